win_valid_ctr: RTL and testbench
================================

# win_valid_ctr

Parametrised successor to the line-buffer warm-up counter in the HOG pipeline. It tracks the raster position of every accepted pixel in a streaming frame. It asserts `o_valid` only for pixels that complete a full WIN_W×WIN_H window at the configured stride, and reports that window's top-left coordinate. It sits beside the line buffers, between the pixel source and the gradient/cell stage. It rearms automatically at frame end.

## Interface
- `IMG_W`, 40: pixels per row; must be ≥ 2.
- `IMG_H`, 30: rows per frame; must be ≥ 2.
- `WIN_W`, 3: window width; 1 ≤ WIN_W ≤ IMG_W.
- `WIN_H`, 3: window height; 1 ≤ WIN_H ≤ IMG_H.
- `STRIDE_X`, 1: horizontal window step; must be ≥ 1.
- `STRIDE_Y`, 1: vertical window step; must be ≥ 1.
- `clk`  in  1  the clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `clear`  in  1  synchronous frame abort; highest priority after reset.
- `i_valid`  in  1  one pixel accepted this cycle.
- `o_valid`  out  1  combinational; the pixel accepted this cycle completes an emitted window.
- `o_win_x`  out  XW=$clog2(IMG_W)  window left column, valid when `o_valid`.
- `o_win_y`  out  YW=$clog2(IMG_H)  window top row, valid when `o_valid`.
- `o_frame_done`  out  1  registered one-cycle pulse after the last pixel of a frame.
- `o_state`  out  2  current state, for debug.

## Operation
- Registers:
  - `x` (XW bits) and `y` (YW bits) hold the coordinate of the next pixel to be accepted.
  - `sx`, `sy` are stride phase counters.
  - `state` holds the FSM state.
- States:
  - IDLE=0: at position (0,0), no pixel accepted yet.
  - FILL=1: y < WIN_H−1.
  - RUN=2: y ≥ WIN_H−1.
  - Encoding 3 is illegal and recovers to IDLE.
- Transitions, taken only on an accepted pixel (`i_valid`=1, `clear`=0):
  - IDLE→FILL, or IDLE→RUN directly when WIN_H=1.
  - FILL→RUN on the row wrap that makes y = WIN_H−1.
  - RUN→IDLE on the last pixel (x=IMG_W−1, y=IMG_H−1).
- Counter advance per accepted pixel:
  - x increments and wraps to 0 after IMG_W−1.
  - On wrap, y increments, and wraps to 0 after IMG_H−1.
- Stride phases:
  - `sx` resets to 0 whenever x = WIN_W−1. Otherwise it counts modulo STRIDE_X while x ≥ WIN_W−1.
  - `sy` behaves the same way against y, WIN_H−1 and STRIDE_Y, advancing only on row wrap.
- `o_valid` = `i_valid` & !`clear` & (x ≥ WIN_W−1) & (y ≥ WIN_H−1) & (sx==0) & (sy==0).
- Window coordinates: `o_win_x` = x−(WIN_W−1) and `o_win_y` = y−(WIN_H−1), computed at full width, never negative when `o_valid`=1. They are don't-care otherwise and are driven 0.
- Windows emitted per frame: ((IMG_W−WIN_W)/STRIDE_X+1) × ((IMG_H−WIN_H)/STRIDE_Y+1), using integer division.
- `clear`:
  - Forces x, y, sx, sy to 0, state to IDLE and `o_valid` to 0.
  - A simultaneous `i_valid` pixel is dropped.
  - No `o_frame_done` pulse results.
- `i_valid` low: nothing changes and `o_valid`=0. Gaps of any length are legal.
- Pixel after frame end: treated as (0,0) of the next frame, with no dead cycle.
- Elaboration: illegal parameters stop elaboration via a generate-time check.

## Timing
- Reset (asynchronous assert, synchronous release on clk):
  - x, y, sx, sy = 0; state = IDLE.
  - `o_frame_done`=0; `o_valid`=0; `o_win_x`/`o_win_y`=0; `o_state`=0.
- Reset asserted mid-frame: all registers clear immediately without waiting for a clock edge. The next accepted pixel is (0,0).
- `o_valid`, `o_win_x`, `o_win_y`: zero latency, combinational from `i_valid` and registers. No combinational path from `clear` to the counters.
- `o_frame_done`: high exactly in the cycle after the last pixel's clock edge, for one cycle. A new frame's first pixel may arrive in that same cycle.
- Fill latency at stride 1: the first `o_valid` occurs on accepted pixel index (WIN_H−1)·IMG_W+(WIN_W−1). This equals the previous block's DEPTH.

## Structure
- Shared package `hog_buf_pkg` holds:
  - state encodings IDLE/FILL/RUN;
  - the width-function helper for XW/YW;
  - the parameter-legality check macro.
  These are reused by the line-buffer blocks.
- One natural sub-module, `wrap_ctr`, instantiated twice (x-axis and y-axis), with parameters N, START and STRIDE:
  - inputs `clk`, `rst`, `clear`, `inc`;
  - outputs `cnt`, `phase`, `wrap` (combinational, cnt==N−1 & inc).
- The top level contains the FSM, the window-coordinate subtractors, the `o_valid` logic and the `o_frame_done` register.

## Test plan
All scenarios use IMG_W=8, IMG_H=6, WIN 3×3 unless stated.
- Stride 1, 48 back-to-back pixels:
  - first `o_valid` on pixel 18 with (0,0);
  - last `o_valid` on pixel 47 with (5,3);
  - exactly 24 `o_valid`;
  - `o_frame_done` in the cycle after pixel 47.
- Same frame with `i_valid` every third cycle:
  - identical 24 windows and coordinates;
  - `o_valid` never high while `i_valid`=0.
- STRIDE_X=2, STRIDE_Y=2:
  - exactly 6 windows, at x∈{0,2,4} and y∈{0,2};
  - first window on pixel 18, last on pixel 38 with (4,2).
- `clear` together with pixel 20:
  - `o_valid`=0, the pixel is dropped, `o_state`=0;
  - the next pixel is (0,0), the first window reappears 18 pixels later, and no `o_frame_done` pulse occurs.
- `rst` low asynchronously mid-RUN at pixel 30:
  - outputs go 0 before the next edge;
  - after release, the full frame repeats the 24-window pattern.
- Two frames back-to-back (96 pixels):
  - `o_frame_done` pulses after pixels 47 and 95;
  - pixel 48 is (0,0) and frame 2 matches frame 1;
  - a WIN 1×1 build yields 48 windows per frame starting at pixel 0.

Source files
------------

// File: rtl/hog_buf_pkg.sv
// Shared definitions for the HOG line-buffer blocks: FSM encodings, counter width helper
// and the elaboration-time parameter legality check.
package hog_buf_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StRun  = 2'd2
    } hog_state_e;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit win_params_ok(
        input int unsigned img_w,
        input int unsigned img_h,
        input int unsigned win_w,
        input int unsigned win_h,
        input int unsigned stride_x,
        input int unsigned stride_y
    );
        return (img_w >= 2) && (img_h >= 2) &&
               (win_w >= 1) && (win_w <= img_w) &&
               (win_h >= 1) && (win_h <= img_h) &&
               (stride_x >= 1) && (stride_y >= 1);
    endfunction

endpackage

`ifndef HOG_BUF_CHECK_PARAMS
`define HOG_BUF_CHECK_PARAMS(iw, ih, ww, wh, sx, sy) \
    if (!hog_buf_pkg::win_params_ok((iw), (ih), (ww), (wh), (sx), (sy))) begin : g_bad_params \
        $error("hog_buf: illegal image/window/stride parameters"); \
    end
`endif

// File: rtl/wrap_ctr.sv
// Modulo-N position counter with a stride phase that restarts at START and cycles
// modulo STRIDE for positions beyond START.
module wrap_ctr
    import hog_buf_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned START  = 0,
    parameter int unsigned STRIDE = 1,
    localparam int unsigned CW    = cnt_width(N),
    localparam int unsigned PW    = cnt_width(STRIDE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic [PW-1:0] phase,
    output logic          wrap
);

    localparam logic [CW-1:0] CntLast   = CW'(N - 1);
    localparam logic [CW-1:0] CntStart  = CW'(START);
    localparam logic [PW-1:0] PhaseLast = PW'(STRIDE - 1);

    logic [CW-1:0] cnt_d, cnt_q;
    logic [PW-1:0] phase_d, phase_q;

    assign wrap  = inc && (cnt_q == CntLast);
    assign cnt   = cnt_q;
    assign phase = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear) begin
            cnt_d   = '0;
            phase_d = '0;
        end else if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            // Phase is relative to the new position: zero at or before START.
            if (cnt_d > CntStart) begin
                phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
            end else begin
                phase_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/win_valid_ctr.sv
// Raster-position tracker for a streaming frame: flags pixels that complete a strided
// WIN_W x WIN_H window and reports the window's top-left corner.
module win_valid_ctr
    import hog_buf_pkg::*;
#(
    parameter int unsigned IMG_W    = 40,
    parameter int unsigned IMG_H    = 30,
    parameter int unsigned WIN_W    = 3,
    parameter int unsigned WIN_H    = 3,
    parameter int unsigned STRIDE_X = 1,
    parameter int unsigned STRIDE_Y = 1,
    localparam int unsigned XW      = cnt_width(IMG_W),
    localparam int unsigned YW      = cnt_width(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          i_valid,
    output logic          o_valid,
    output logic [XW-1:0] o_win_x,
    output logic [YW-1:0] o_win_y,
    output logic          o_frame_done,
    output logic [1:0]    o_state
);

    `HOG_BUF_CHECK_PARAMS(IMG_W, IMG_H, WIN_W, WIN_H, STRIDE_X, STRIDE_Y)

    localparam int unsigned SXW = cnt_width(STRIDE_X);
    localparam int unsigned SYW = cnt_width(STRIDE_Y);

    localparam logic [XW-1:0] XOff = XW'(WIN_W - 1);
    localparam logic [YW-1:0] YOff = YW'(WIN_H - 1);
    // Last fill row: the row wrap out of it enters RUN.
    localparam logic [YW-1:0] YPre = YW'((WIN_H >= 2) ? WIN_H - 2 : 0);

    hog_state_e state_d, state_q;

    logic           accept;
    logic [XW-1:0]  x_q;
    logic [YW-1:0]  y_q;
    logic [SXW-1:0] sx_q;
    logic [SYW-1:0] sy_q;
    logic           x_wrap, y_wrap;
    logic           x_ok, y_ok;
    logic           win_hit;
    logic           done_q;

    assign accept = i_valid && !clear;

    wrap_ctr #(
        .N      (IMG_W),
        .START  (WIN_W - 1),
        .STRIDE (STRIDE_X)
    ) u_x_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (accept),
        .cnt   (x_q),
        .phase (sx_q),
        .wrap  (x_wrap)
    );

    wrap_ctr #(
        .N      (IMG_H),
        .START  (WIN_H - 1),
        .STRIDE (STRIDE_Y)
    ) u_y_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (x_wrap),
        .cnt   (y_q),
        .phase (sy_q),
        .wrap  (y_wrap)
    );

    if (WIN_W > 1) begin : g_x_cmp
        assign x_ok = (x_q >= XOff);
    end else begin : g_x_any
        assign x_ok = 1'b1;
    end

    if (WIN_H > 1) begin : g_y_cmp
        assign y_ok = (y_q >= YOff);
    end else begin : g_y_any
        assign y_ok = 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the unused encoding falls back to IDLE on the next edge
    always_comb begin
        state_d = state_q;
        if (clear || !(state_q inside {StIdle, StFill, StRun})) begin
            state_d = StIdle;
        end else if (accept) begin
            case (state_q)
                StIdle:  state_d = (WIN_H == 1) ? StRun : StFill;
                StFill:  if (x_wrap && (y_q == YPre)) state_d = StRun;
                StRun:   if (y_wrap) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM / datapath outputs
    always_comb begin
        o_state = state_q;
        win_hit = rst && accept && x_ok && y_ok && (sx_q == '0) && (sy_q == '0);
        o_valid = win_hit;
        o_win_x = '0;
        o_win_y = '0;
        if (win_hit) begin
            o_win_x = x_q - XOff;
            o_win_y = y_q - YOff;
        end
    end

    // y_wrap already implies an accepted last pixel, so clear never produces a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= y_wrap;
        end
    end

    assign o_frame_done = done_q;

endmodule

// File: tb/tb_win_valid_ctr.sv
// Bench for win_valid_ctr: three builds on an 8x6 image (3x3 stride 1, 3x3 stride 2,
// 1x1) share one stimulus stream and are compared every cycle with a pixel-index model.
`timescale 1ns/1ps
module tb_win_valid_ctr;

    localparam int IW   = 8;
    localparam int IH   = 6;
    localparam int NPIX = IW * IH;
    localparam int NDUT = 3;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic clear   = 1'b0;
    logic i_valid = 1'b0;

    logic       ov [NDUT];
    logic [2:0] wx [NDUT];
    logic [2:0] wy [NDUT];
    logic       fd [NDUT];
    logic [1:0] st [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int p        = 0;
    bit done_exp = 1'b0;
    // k*4096 + pixel*64 + win_x*8 + win_y for every observed o_valid
    int hist[$];

    always #5 clk = ~clk;

    win_valid_ctr #(
        .IMG_W(IW), .IMG_H(IH), .WIN_W(3), .WIN_H(3), .STRIDE_X(1), .STRIDE_Y(1)
    ) u_s1 (
        .clk(clk), .rst(rst), .clear(clear), .i_valid(i_valid), .o_valid(ov[0]),
        .o_win_x(wx[0]), .o_win_y(wy[0]), .o_frame_done(fd[0]), .o_state(st[0])
    );

    win_valid_ctr #(
        .IMG_W(IW), .IMG_H(IH), .WIN_W(3), .WIN_H(3), .STRIDE_X(2), .STRIDE_Y(2)
    ) u_s2 (
        .clk(clk), .rst(rst), .clear(clear), .i_valid(i_valid), .o_valid(ov[1]),
        .o_win_x(wx[1]), .o_win_y(wy[1]), .o_frame_done(fd[1]), .o_state(st[1])
    );

    win_valid_ctr #(
        .IMG_W(IW), .IMG_H(IH), .WIN_W(1), .WIN_H(1), .STRIDE_X(1), .STRIDE_Y(1)
    ) u_w1 (
        .clk(clk), .rst(rst), .clear(clear), .i_valid(i_valid), .o_valid(ov[2]),
        .o_win_x(wx[2]), .o_win_y(wy[2]), .o_frame_done(fd[2]), .o_state(st[2])
    );

    function automatic int ww(input int k); return (k == 2) ? 1 : 3; endfunction
    function automatic int wh(input int k); return (k == 2) ? 1 : 3; endfunction
    function automatic int sx(input int k); return (k == 1) ? 2 : 1; endfunction
    function automatic int sy(input int k); return (k == 1) ? 2 : 1; endfunction

    function automatic bit exp_hit(input int k, input int pix);
        int x;
        int y;
        x = pix % IW;
        y = pix / IW;
        return (x >= ww(k) - 1) && (y >= wh(k) - 1) &&
               ((x - (ww(k) - 1)) % sx(k) == 0) && ((y - (wh(k) - 1)) % sy(k) == 0);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: index of the next pixel within the frame, and the expected done pulse.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p        <= 0;
            done_exp <= 1'b0;
        end else if (clear) begin
            p        <= 0;
            done_exp <= 1'b0;
        end else if (i_valid) begin
            done_exp <= (p == NPIX - 1);
            p        <= (p + 1) % NPIX;
        end else begin
            done_exp <= 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            bit hit;
            int ex;
            int ey;
            int es;
            hit = rst && i_valid && !clear && exp_hit(k, p);
            ex  = hit ? (p % IW) - (ww(k) - 1) : 0;
            ey  = hit ? (p / IW) - (wh(k) - 1) : 0;
            es  = (p == 0) ? 0 : (((p / IW) < wh(k) - 1) ? 1 : 2);
            check($sformatf("u%0d.o_valid", k), int'(ov[k]), int'(hit));
            check($sformatf("u%0d.o_win_x", k), int'(wx[k]), ex);
            check($sformatf("u%0d.o_win_y", k), int'(wy[k]), ey);
            check($sformatf("u%0d.o_state", k), int'(st[k]), es);
            check($sformatf("u%0d.o_frame_done", k), int'(fd[k]), int'(done_exp));
            if (ov[k] === 1'b1) hist.push_back(k * 4096 + p * 64 + int'(wx[k]) * 8 + int'(wy[k]));
        end
        if (fd[0] === 1'b1) n_done++;
    end

    task automatic px(input bit v, input bit c);
        i_valid = v;
        clear   = c;
        @(posedge clk);
        #1;
    endtask

    // Literal per-section expectations for one build, from hist entries since index s.
    task automatic expect_wins(input string tag, input int s, input int k, input int ecnt,
                               input int efirst, input int elast, input int efx, input int efy,
                               input int elx, input int ely);
        int cnt;
        int first;
        int last;
        int fx;
        int fy;
        int lx;
        int ly;
        cnt = 0; first = -1; last = -1; fx = -1; fy = -1; lx = -1; ly = -1;
        for (int i = s; i < hist.size(); i++) begin
            if (hist[i] / 4096 == k) begin
                int r;
                r = hist[i] % 4096;
                if (cnt == 0) begin
                    first = r / 64; fx = (r / 8) % 8; fy = r % 8;
                end
                last = r / 64; lx = (r / 8) % 8; ly = r % 8;
                cnt++;
            end
        end
        check({tag, ".count"}, cnt, ecnt);
        check({tag, ".first_pixel"}, first, efirst);
        check({tag, ".last_pixel"}, last, elast);
        check({tag, ".first_x"}, fx, efx);
        check({tag, ".first_y"}, fy, efy);
        check({tag, ".last_x"}, lx, elx);
        check({tag, ".last_y"}, ly, ely);
    endtask

    initial begin
        int s;
        int d;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.o_state", int'(st[0]), 0);
        check("reset.o_frame_done", int'(fd[0]), 0);
        check("reset.o_valid", int'(ov[2]), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back frame
        s = hist.size(); d = n_done;
        repeat (NPIX) px(1'b1, 1'b0);
        px(1'b0, 1'b0);
        expect_wins("b2b.s1", s, 0, 24, 18, 47, 0, 0, 5, 3);
        expect_wins("b2b.s2", s, 1, 6, 18, 38, 0, 0, 4, 2);
        expect_wins("b2b.w1", s, 2, 48, 0, 47, 0, 0, 7, 5);
        check("b2b.frame_done_pulses", n_done - d, 1);

        // One pixel every third cycle
        s = hist.size(); d = n_done;
        repeat (NPIX) begin
            px(1'b1, 1'b0);
            px(1'b0, 1'b0);
            px(1'b0, 1'b0);
        end
        expect_wins("gap.s1", s, 0, 24, 18, 47, 0, 0, 5, 3);
        check("gap.frame_done_pulses", n_done - d, 1);

        // Clear with pixel 20
        repeat (20) px(1'b1, 1'b0);
        i_valid = 1'b1;
        clear   = 1'b1;
        #1;
        check("clear.o_valid", int'(ov[0]), 0);
        @(posedge clk);
        #1;
        check("clear.o_state", int'(st[0]), 0);
        s = hist.size(); d = n_done;
        repeat (40) px(1'b1, 1'b0);
        px(1'b0, 1'b0);
        expect_wins("clear.s1", s, 0, 18, 18, 39, 0, 0, 5, 2);
        check("clear.frame_done_pulses", n_done - d, 0);
        repeat (8) px(1'b1, 1'b0);
        px(1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN
        repeat (30) px(1'b1, 1'b0);
        i_valid = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check("arst.o_state", int'(st[0]), 0);
        check("arst.o_valid", int'(ov[0]), 0);
        check("arst.o_win_x", int'(wx[0]), 0);
        check("arst.o_frame_done", int'(fd[0]), 0);
        @(posedge clk);
        #1;
        px(1'b0, 1'b0);
        rst = 1'b1;
        s = hist.size(); d = n_done;
        repeat (NPIX) px(1'b1, 1'b0);
        px(1'b0, 1'b0);
        expect_wins("arst.s1", s, 0, 24, 18, 47, 0, 0, 5, 3);
        check("arst.frame_done_pulses", n_done - d, 1);

        // Two frames back-to-back
        s = hist.size(); d = n_done;
        repeat (2 * NPIX) px(1'b1, 1'b0);
        px(1'b0, 1'b0);
        expect_wins("two.s1", s, 0, 48, 18, 47, 0, 0, 5, 3);
        expect_wins("two.s2", s, 1, 12, 18, 38, 0, 0, 4, 2);
        expect_wins("two.w1", s, 2, 96, 0, 47, 0, 0, 7, 5);
        check("two.frame_done_pulses", n_done - d, 2);

        // Random traffic with occasional clears
        repeat (2000) begin
            px(($urandom_range(0, 99) < 70), ($urandom_range(0, 199) == 0));
        end
        px(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
